// File: rtl/i2c_write_seq_pkg.sv
// rtl/i2c_write_seq_pkg.sv - shared state, quarter-phase and counter-width constants
package i2c_write_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        BITS  = 3'd2,
        ACK   = 3'd3,
        STOP  = 3'd4,
        GAP   = 3'd5,
        DONE  = 3'd6
    } state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam int BIT_CNT_W = 3;

endpackage

// File: rtl/i2c_qtick.sv
// rtl/i2c_qtick.sv - quarter-SCL-period tick divider, one tick every QDIV clocks
module i2c_qtick #(
    parameter int unsigned QDIV = 1
) (
    input  logic CLK,
    input  logic SW0,
    output logic tick
);

    logic [15:0] qcnt;

    assign tick = (qcnt == 16'(QDIV - 1));

    always_ff @(posedge CLK or negedge SW0) begin
        if (!SW0) begin
            qcnt <= '0;
        end else if (tick) begin
            qcnt <= '0;
        end else begin
            qcnt <= qcnt + 16'd1;
        end
    end

endmodule

// File: rtl/i2c_write_seq.sv
// rtl/i2c_write_seq.sv - self-starting open-drain I2C write sequencer
// Optional: NACK_ABORT_EN skips the data byte after an address NACK.
module i2c_write_seq
    import i2c_write_seq_pkg::*;
#(
    parameter logic [6:0]  ADDR      = 7'h3C,
    parameter logic [7:0]  DATA_BASE = 8'hA5,
    parameter int unsigned NUM_TRANS = 3,
    parameter int unsigned QDIV      = 1,
    parameter int unsigned IDLE_Q    = 8
) (
    input  logic CLK,
    input  logic SW0,
    inout  wire  SDA,
    output wire  SCL,
    output logic ack_ok
);

    localparam logic [2:0]  S_IDLE    = IDLE;
    localparam logic [2:0]  S_START   = START;
    localparam logic [2:0]  S_BITS    = BITS;
    localparam logic [2:0]  S_ACK     = ACK;
    localparam logic [2:0]  S_STOP    = STOP;
    localparam logic [2:0]  S_GAP     = GAP;
    localparam logic [2:0]  S_DONE    = DONE;
    localparam logic [3:0]  NUM_T     = 4'(NUM_TRANS);
    localparam logic [15:0] IDLE_LAST = 16'(IDLE_Q - 1);
    localparam logic [7:0]  ADDR_BYTE = {ADDR, 1'b0};

    logic                 tick;
    logic [2:0]           state;
    logic [1:0]           qph;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [3:0]           trans_cnt;
    logic [15:0]          wait_cnt;
    logic [7:0]           shreg;
    logic                 data_phase;
    logic                 sda_oe;
    logic                 scl_oe;
    logic                 sda_in;
    logic                 abort;
    logic [7:0]           data_byte;

    i2c_qtick #(.QDIV(QDIV)) u_qtick (
        .CLK  (CLK),
        .SW0  (SW0),
        .tick (tick)
    );

    // Open-drain pins: the enables only ever pull low, release means Z.
    assign SDA       = sda_oe ? 1'b0 : 1'bz;
    assign SCL       = scl_oe ? 1'b0 : 1'bz;
    assign sda_in    = SDA;
    assign data_byte = DATA_BASE + {4'd0, trans_cnt};

`ifdef NACK_ABORT_EN
    assign abort = !ack_ok;
`else
    assign abort = 1'b0;
`endif

    // Each tick moves to the next quarter; the registered actions belong to the quarter entered.
    always_ff @(posedge CLK or negedge SW0) begin
        if (!SW0) begin
            state      <= S_IDLE;
            qph        <= Q0;
            bit_cnt    <= '0;
            trans_cnt  <= '0;
            wait_cnt   <= '0;
            shreg      <= '0;
            data_phase <= 1'b0;
            sda_oe     <= 1'b0;
            scl_oe     <= 1'b0;
            ack_ok     <= 1'b0;
        end else if (tick) begin
            case (state)
                S_IDLE: begin
                    if (wait_cnt == 16'd3) begin
                        state    <= S_START;
                        qph      <= Q0;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_START: begin
                    qph <= qph + 2'd1;
                    case (qph)
                        Q0: sda_oe <= 1'b1;
                        Q1: scl_oe <= 1'b1;
                        Q3: begin
                            state      <= S_BITS;
                            bit_cnt    <= '0;
                            data_phase <= 1'b0;
                            shreg      <= ADDR_BYTE;
                            sda_oe     <= !ADDR_BYTE[7];
                        end
                        default: ;
                    endcase
                end
                S_BITS: begin
                    qph <= qph + 2'd1;
                    case (qph)
                        Q0: scl_oe <= 1'b0;
                        Q2: scl_oe <= 1'b1;
                        Q3: begin
                            if (bit_cnt == 3'd7) begin
                                state  <= S_ACK;
                                sda_oe <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                shreg   <= {shreg[6:0], 1'b0};
                                sda_oe  <= !shreg[6];
                            end
                        end
                        default: ;
                    endcase
                end
                S_ACK: begin
                    qph <= qph + 2'd1;
                    case (qph)
                        Q0: scl_oe <= 1'b0;
                        Q2: begin
                            scl_oe <= 1'b1;
                            ack_ok <= !sda_in;
                        end
                        Q3: begin
                            if (!data_phase && !abort) begin
                                state      <= S_BITS;
                                data_phase <= 1'b1;
                                bit_cnt    <= '0;
                                shreg      <= data_byte;
                                sda_oe     <= !data_byte[7];
                            end else begin
                                state      <= S_STOP;
                                data_phase <= 1'b0;
                                sda_oe     <= 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
                S_STOP: begin
                    qph <= qph + 2'd1;
                    case (qph)
                        Q0: scl_oe <= 1'b0;
                        Q1: begin
                            sda_oe <= 1'b0;
                            if (trans_cnt != NUM_T) begin
                                trans_cnt <= trans_cnt + 4'd1;
                            end
                        end
                        Q3: begin
                            state    <= S_GAP;
                            wait_cnt <= '0;
                        end
                        default: ;
                    endcase
                end
                S_GAP: begin
                    if (wait_cnt == IDLE_LAST) begin
                        wait_cnt <= '0;
                        qph      <= Q0;
                        state    <= (trans_cnt < NUM_T) ? S_START : S_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                S_DONE: ;
                default: state <= S_DONE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_seq.sv
// tb/tb_i2c_write_seq.sv - quarter-level bus model, slave monitor and reset-restart checks
`timescale 1ns/1ps
module tb_i2c_write_seq;

    localparam logic [6:0] ADDR      = 7'h3C;
    localparam logic [7:0] DATA_BASE = 8'hA5;
    localparam int         NT        = 3;
    localparam int         QDIV      = 2;
    localparam int         IDLE_Q    = 8;
`ifdef NACK_ABORT_EN
    localparam bit ABORT      = 1'b1;
    localparam bit ACK_ADDR   = 1'b0;
    localparam int TLEN       = 4 + 36 + 4 + IDLE_Q;
    localparam int MODEL_LEN  = 160;
`else
    localparam bit ABORT      = 1'b0;
    localparam bit ACK_ADDR   = 1'b1;
    localparam int TLEN       = 4 + 36 + 36 + 4 + IDLE_Q;
    localparam int MODEL_LEN  = 268;
`endif
    localparam int PULSE_CYC  = (4 + 2 * TLEN + 53) * QDIV;

    logic CLK = 1'b0;
    logic SW0 = 1'b0;
    wire  SDA;
    wire  SCL;
    logic ack_ok;
    logic slave_drv = 1'b0;

    pullup (SDA);
    pullup (SCL);
    assign SDA = slave_drv ? 1'b0 : 1'bz;

    i2c_write_seq #(
        .ADDR(ADDR), .DATA_BASE(DATA_BASE), .NUM_TRANS(NT), .QDIV(QDIV), .IDLE_Q(IDLE_Q)
    ) dut (
        .CLK    (CLK),
        .SW0    (SW0),
        .SDA    (SDA),
        .SCL    (SCL),
        .ack_ok (ack_ok)
    );

    always #50000 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line levels per quarter, built from the protocol description.
    bit         exp_scl[$];
    bit         exp_sda[$];
    bit         ack_chk[$];
    bit         ack_val[$];
    logic [7:0] exp_bytes[$];
    bit         pend_chk = 1'b0;
    bit         pend_val = 1'b0;

    task automatic push_q(input bit c, input bit d);
        exp_scl.push_back(c);
        exp_sda.push_back(d);
        ack_chk.push_back(pend_chk);
        ack_val.push_back(pend_val);
        pend_chk = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            push_q(1'b0, b[i]); push_q(1'b1, b[i]); push_q(1'b1, b[i]); push_q(1'b0, b[i]);
        end
        exp_bytes.push_back(b);
    endtask

    task automatic push_ack(input bit acked);
        push_q(1'b0, 1'b1); push_q(1'b1, 1'b1); push_q(1'b1, 1'b1); push_q(1'b0, 1'b1);
        pend_chk = 1'b1;
        pend_val = acked;
    endtask

    task automatic build_model();
        logic [7:0] d;
        repeat (4) push_q(1'b1, 1'b1);
        for (int t = 0; t < NT; t++) begin
            push_q(1'b1, 1'b1); push_q(1'b1, 1'b0); push_q(1'b0, 1'b0); push_q(1'b0, 1'b0);
            push_byte({ADDR, 1'b0});
            push_ack(ACK_ADDR);
            if (!ABORT || ACK_ADDR) begin
                d = DATA_BASE + 8'(t);
                push_byte(d);
                push_ack(1'b0);
            end
            push_q(1'b0, 1'b0); push_q(1'b1, 1'b0); push_q(1'b1, 1'b1); push_q(1'b1, 1'b1);
            repeat (IDLE_Q) push_q(1'b1, 1'b1);
        end
    endtask

    // Slave/bus monitor: decodes START/STOP and bytes, ACKs per policy.
    int         n_start = 0;
    int         n_stop  = 0;
    int         bitn    = 0;
    int         bsel    = 0;
    bit         in_frame = 1'b0;
    logic [7:0] sh = '0;
    logic [7:0] got_bytes[$];
    logic       p_sda = 1'b1;
    logic       p_scl = 1'b1;

    always @(SDA or SCL or SW0) begin
        if (!SW0) begin
            n_start = 0; n_stop = 0; bitn = 0; bsel = 0;
            in_frame = 1'b0; slave_drv = 1'b0;
            got_bytes.delete();
        end else if (SCL && p_scl && p_sda && !SDA) begin
            n_start++; in_frame = 1'b1; bitn = 0; bsel = 0; sh = '0;
        end else if (SCL && p_scl && !p_sda && SDA) begin
            n_stop++; in_frame = 1'b0;
        end else if (in_frame && SCL && !p_scl) begin
            if (bitn < 8) sh = {sh[6:0], SDA};
            bitn++;
        end else if (in_frame && !SCL && p_scl) begin
            if (bitn == 8) begin
                slave_drv = (bsel == 0) ? ACK_ADDR : 1'b0;
            end else if (bitn == 9) begin
                slave_drv = 1'b0;
                got_bytes.push_back(sh);
                bsel++;
                bitn = 0;
            end
        end
        p_sda = SDA;
        p_scl = SCL;
    end

    int cyc = 0;
    always @(posedge CLK or negedge SW0) begin
        if (!SW0) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    bit   run_en     = 1'b0;
    bit   seen_fall  = 1'b0;
    int   first_fall = -1;
    int   k;
    logic ec, ed;

    always @(negedge CLK) begin
        if (!SW0) begin
            seen_fall = 1'b0;
        end else if (run_en) begin
            k  = cyc / QDIV;
            ec = 1'b1;
            ed = 1'b1;
            if (k < exp_scl.size()) begin
                ec = exp_scl[k];
                ed = exp_sda[k];
            end
            ed = ed & ~slave_drv;
            chk("scl_line", {31'd0, SCL}, {31'd0, ec});
            chk("sda_line", {31'd0, SDA}, {31'd0, ed});
            if (k < exp_scl.size() && ack_chk[k] && (cyc % QDIV) == 0)
                chk("ack_ok", {31'd0, ack_ok}, {31'd0, ack_val[k]});
            if (!seen_fall && SCL === 1'b1 && SDA === 1'b0) begin
                seen_fall  = 1'b1;
                first_fall = cyc;
            end
        end
    end

    task automatic reset_phase(input int n);
        @(negedge CLK);
        SW0 = 1'b0;
        repeat (n) @(negedge CLK);
        chk("rst_scl", {31'd0, SCL}, 32'd1);
        chk("rst_sda", {31'd0, SDA}, 32'd1);
        chk("rst_ack_ok", {31'd0, ack_ok}, 32'd0);
        SW0 = 1'b1;
        run_en = 1'b1;
    endtask

    task automatic end_checks();
        chk("starts", n_start, NT);
        chk("stops", n_stop, 3);
        chk("first_fall_latency", first_fall, 5 * QDIV);
        chk("byte_count", got_bytes.size(), exp_bytes.size());
        for (int i = 0; i < exp_bytes.size() && i < got_bytes.size(); i++)
            chk("byte", {24'd0, got_bytes[i]}, {24'd0, exp_bytes[i]});
        if (got_bytes.size() >= 2) begin
            chk("lit_addr_byte", {24'd0, got_bytes[0]}, 32'h78);
`ifdef NACK_ABORT_EN
            chk("lit_second_byte", {24'd0, got_bytes[1]}, 32'h78);
`else
            chk("lit_data_byte", {24'd0, got_bytes[1]}, 32'hA5);
`endif
        end
    endtask

    initial begin
        build_model();
        chk("model_len", exp_scl.size(), MODEL_LEN);

        reset_phase(100);
        repeat (MODEL_LEN * QDIV + 60) @(posedge CLK);
        @(negedge CLK);
        run_en = 1'b0;
        end_checks();

        reset_phase(5);
        repeat (PULSE_CYC) @(posedge CLK);
        #20000;
        run_en = 1'b0;
        SW0 = 1'b0;
        #1;
        chk("pulse_scl_released", {31'd0, SCL}, 32'd1);
        chk("pulse_sda_released", {31'd0, SDA}, 32'd1);

        reset_phase(5);
        repeat (MODEL_LEN * QDIV + 60) @(posedge CLK);
        @(negedge CLK);
        run_en = 1'b0;
        end_checks();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
